// File: rtl/fc_inneuron_writer.sv
// ---------------------------------------------------------------------------
// fc_inneuron_writer
//
// Fills the FC layer's PI input-neuron RAM banks from the upstream
// (pooling/flatten) output stream. Words are written sequentially through
// port A of each bank: word n lands in bank n/(INNEURON/PI) at address
// n mod (INNEURON/PI). After INNEURON words the buffer is flagged full and
// input is stalled until the FC compute side releases it.
//
// Handshake: a word is accepted on a rising clock edge where
// in_valid_i && in_ready_o. in_ready_o is combinational and only depends on
// the current state and enable_i. in_valid_i may be asserted without waiting
// for in_ready_o, and in_data_i must be stable while in_valid_i is high.
//
// Ports:
//   clock_i                 system clock, rising edge
//   reset_i                 asynchronous active-high reset
//   enable_i                block enable; also starts a pass from IDLE
//   in_valid_i / in_data_i  upstream neuron word stream
//   in_ready_o              upstream ready: FILL state and enable_i
//   in_neuron_wren_a_all_o  registered one-hot port-A write enable per bank
//   in_neuron_addr_a_o      registered port-A address shared by all banks
//   in_neuron_data_a_o      registered port-A data shared by all banks
//   buffer_full_o           registered level, high while in FULL
//   fill_done_o             registered one-cycle pulse on entry to FULL
//   release_i               FC compute side has consumed the buffer
//   word_count_o            words accepted in the current pass
//   state_o                 FSM state (0 IDLE, 1 FILL, 2 FULL) for debug
// ---------------------------------------------------------------------------
module fc_inneuron_writer #(
    parameter int INNEURON               = 64,
    parameter int PI                     = 4,
    parameter int DATA_WIDTH_FC          = 16,
    parameter int FC_INNEURON_ADDR_WIDTH = 4,
    parameter int FC_WORD_CNT_WIDTH      = 7
) (
    input  logic                              clock_i,
    input  logic                              reset_i,
    input  logic                              enable_i,
    input  logic                              in_valid_i,
    input  logic [DATA_WIDTH_FC-1:0]          in_data_i,
    output logic                              in_ready_o,
    output logic [PI-1:0]                     in_neuron_wren_a_all_o,
    output logic [FC_INNEURON_ADDR_WIDTH-1:0] in_neuron_addr_a_o,
    output logic [DATA_WIDTH_FC-1:0]          in_neuron_data_a_o,
    output logic                              buffer_full_o,
    output logic                              fill_done_o,
    input  logic                              release_i,
    output logic [FC_WORD_CNT_WIDTH-1:0]      word_count_o,
    output logic [1:0]                        state_o
);

    localparam int WORDS_PER_BANK = INNEURON / PI;
    localparam int BANK_W         = (PI > 1) ? $clog2(PI) : 1;

    localparam logic [FC_INNEURON_ADDR_WIDTH-1:0] LAST_ADDR =
        FC_INNEURON_ADDR_WIDTH'(WORDS_PER_BANK - 1);
    localparam logic [FC_WORD_CNT_WIDTH-1:0] LAST_WORD =
        FC_WORD_CNT_WIDTH'(INNEURON - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t                              state_q;
    logic [FC_WORD_CNT_WIDTH-1:0]        word_count_q;
    logic [BANK_W-1:0]                   bank_idx_q;
    logic [FC_INNEURON_ADDR_WIDTH-1:0]   addr_cnt_q;
    logic [PI-1:0]                       wren_q;
    logic [FC_INNEURON_ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH_FC-1:0]            data_q;
    logic                                full_q;
    logic                                done_q;

    logic                                accept;

    assign in_ready_o = (state_q == ST_FILL) && enable_i;
    assign accept     = in_valid_i && in_ready_o;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            word_count_q <= '0;
            bank_idx_q   <= '0;
            addr_cnt_q   <= '0;
            wren_q       <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            full_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // Strobe and pulse default low so each lasts exactly one cycle.
            wren_q <= '0;
            done_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        state_q <= ST_FILL;
                    end
                end

                ST_FILL: begin
                    if (accept) begin
                        wren_q       <= PI'(1) << bank_idx_q;
                        addr_q       <= addr_cnt_q;
                        data_q       <= in_data_i;
                        word_count_q <= word_count_q + 1'b1;

                        if (word_count_q == LAST_WORD) begin
                            // Last word: park both counters at the start of
                            // bank 0 so the next pass begins cleanly.
                            state_q    <= ST_FULL;
                            full_q     <= 1'b1;
                            done_q     <= 1'b1;
                            bank_idx_q <= '0;
                            addr_cnt_q <= '0;
                        end else if (addr_cnt_q == LAST_ADDR) begin
                            addr_cnt_q <= '0;
                            bank_idx_q <= bank_idx_q + 1'b1;
                        end else begin
                            addr_cnt_q <= addr_cnt_q + 1'b1;
                        end
                    end
                end

                ST_FULL: begin
                    if (release_i) begin
                        state_q      <= ST_IDLE;
                        full_q       <= 1'b0;
                        word_count_q <= '0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_neuron_wren_a_all_o = wren_q;
    assign in_neuron_addr_a_o     = addr_q;
    assign in_neuron_data_a_o     = data_q;
    assign buffer_full_o          = full_q;
    assign fill_done_o            = done_q;
    assign word_count_o           = word_count_q;
    assign state_o                = state_q;

endmodule

// File: tb/tb_fc_inneuron_writer.sv
// ---------------------------------------------------------------------------
// tb_fc_inneuron_writer
//
// Directed bench for fc_inneuron_writer. A small reference model tracks the
// pass state and word count from the driven inputs and queues the expected
// port-A write for every accepted word; a negedge monitor compares the DUT
// outputs against it every cycle. Directed checks cover the hand-computed
// write positions, back-pressure, release handling and mid-fill reset.
// ---------------------------------------------------------------------------
module tb_fc_inneuron_writer;

    localparam int INNEURON = 64;
    localparam int PI       = 4;
    localparam int DW       = 16;
    localparam int AW       = 4;
    localparam int CW       = 7;
    localparam int WPB      = INNEURON / PI;
    localparam int WR_W     = PI + AW + DW;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          enable   = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          release_in = 1'b0;

    logic          in_ready;
    logic [PI-1:0] wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          buffer_full;
    logic          fill_done;
    logic [CW-1:0] word_count;
    logic [1:0]    state;

    fc_inneuron_writer dut (
        .clock_i                (clock),
        .reset_i                (reset),
        .enable_i               (enable),
        .in_valid_i             (in_valid),
        .in_data_i              (in_data),
        .in_ready_o             (in_ready),
        .in_neuron_wren_a_all_o (wren),
        .in_neuron_addr_a_o     (addr),
        .in_neuron_data_a_o     (wdata),
        .buffer_full_o          (buffer_full),
        .fill_done_o            (fill_done),
        .release_i              (release_in),
        .word_count_o           (word_count),
        .state_o                (state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic tb_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_FILL = 2'd1;
    localparam logic [1:0] M_FULL = 2'd2;

    logic [1:0]      m_state = M_IDLE;
    int              m_count = 0;
    logic            m_full  = 1'b0;
    logic            m_done  = 1'b0;
    logic [WR_W-1:0] exp_q[$];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_state = M_IDLE;
            m_count = 0;
            m_full  = 1'b0;
            m_done  = 1'b0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            case (m_state)
                M_IDLE: if (enable) m_state = M_FILL;
                M_FILL: begin
                    if (enable && in_valid) begin
                        logic [PI-1:0] oh;
                        logic [AW-1:0] a;
                        oh = '0;
                        oh[m_count / WPB] = 1'b1;
                        a = AW'(m_count % WPB);
                        exp_q.push_back({oh, a, in_data});
                        m_count++;
                        if (m_count == INNEURON) begin
                            m_state = M_FULL;
                            m_full  = 1'b1;
                            m_done  = 1'b1;
                        end
                    end
                end
                default: begin
                    if (release_in) begin
                        m_state = M_IDLE;
                        m_full  = 1'b0;
                        m_count = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [WR_W-1:0] write_log[$];

    always @(negedge clock) begin
        logic [WR_W-1:0] exp_wr;
        exp_wr = '0;
        if (exp_q.size() > 0) exp_wr = exp_q.pop_front();
        if (wren !== '0) write_log.push_back({wren, addr, wdata});
        if (exp_wr[WR_W-1 -: PI] == '0)
            tb_check("wren_idle", 32'(wren), 32'(0));
        else
            tb_check("write", 32'({wren, addr, wdata}), 32'(exp_wr));
        tb_check("in_ready", 32'(in_ready), 32'(m_state == M_FILL && enable));
        tb_check("buffer_full", 32'(buffer_full), 32'(m_full));
        tb_check("fill_done", 32'(fill_done), 32'(m_done));
        tb_check("word_count", 32'(word_count), 32'(m_count));
        tb_check("state", 32'(state), 32'(m_state));
    end

    function automatic logic [WR_W-1:0] log_at(input int idx);
        if (idx < write_log.size()) return write_log[idx];
        return '0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_release();
        release_in = 1'b1;
        step();
        release_in = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        bit dropped;
        bit rel_done;

        // Reset / idle
        repeat (3) step();
        reset = 1'b0;
        enable = 1'b1;
        in_valid = 1'b0;
        tb_check("idle_ready", 32'(in_ready), 32'(0));
        tb_check("idle_wren", 32'(wren), 32'(0));
        tb_check("idle_count", 32'(word_count), 32'(0));
        step();
        tb_check("fill_ready", 32'(in_ready), 32'(1));
        tb_check("fill_state", 32'(state), 32'(1));

        // Full back-to-back pass
        write_log.delete();
        for (int k = 0; k < INNEURON; k++) begin
            in_valid = 1'b1;
            in_data  = 16'hA000 + 16'(k);
            step();
        end
        tb_check("p1_full", 32'(buffer_full), 32'(1));
        tb_check("p1_done", 32'(fill_done), 32'(1));
        tb_check("p1_count", 32'(word_count), 32'(64));
        tb_check("p1_last_wren", 32'(wren), 32'(4'b1000));
        tb_check("p1_last_addr", 32'(addr), 32'(15));
        step();
        tb_check("p1_done_pulse", 32'(fill_done), 32'(0));

        // Back-pressure in FULL
        for (int i = 0; i < 9; i++) begin
            tb_check("bp_ready", 32'(in_ready), 32'(0));
            tb_check("bp_wren", 32'(wren), 32'(0));
            step();
        end
        tb_check("p1_log_size", 32'(write_log.size()), 32'(64));
        tb_check("p1_word17", 32'(log_at(17)), 32'({4'b0010, 4'd1, 16'hA011}));
        tb_check("p1_word63", 32'(log_at(63)), 32'({4'b1000, 4'd15, 16'hA03F}));
        tb_check("p1_word0", 32'(log_at(0)), 32'({4'b0001, 4'd0, 16'hA000}));

        in_valid = 1'b0;
        tb_check("rel_cycle_ready", 32'(in_ready), 32'(0));
        do_release();
        tb_check("rel_full", 32'(buffer_full), 32'(0));
        tb_check("rel_count", 32'(word_count), 32'(0));
        tb_check("rel_state", 32'(state), 32'(0));

        // Gapped pass with enable drop and ignored release
        step();
        tb_check("p2_state", 32'(state), 32'(1));
        write_log.delete();
        cyc = 0;
        dropped = 1'b0;
        rel_done = 1'b0;
        while (m_state != M_FULL && cyc < 1000) begin
            if (!dropped && m_count == 36) begin
                enable   = 1'b0;
                in_valid = 1'b1;
                repeat (5) step();
                tb_check("drop_hold", 32'(word_count), 32'(36));
                tb_check("drop_ready", 32'(in_ready), 32'(0));
                enable  = 1'b1;
                dropped = 1'b1;
            end
            in_valid = (cyc % 2 == 0);
            in_data  = 16'hB000 + 16'(m_count);
            if (!rel_done && m_count == 40 && in_valid) begin
                release_in = 1'b1;
                step();
                release_in = 1'b0;
                rel_done = 1'b1;
                tb_check("rel_ignored", 32'(state), 32'(1));
                tb_check("rel_ignored_cnt", 32'(word_count), 32'(41));
            end else begin
                step();
            end
            cyc++;
        end
        in_valid = 1'b0;
        if (cyc >= 1000) tb_check("p2_timeout", 32'(0), 32'(1));
        step();
        tb_check("p2_count", 32'(word_count), 32'(64));
        tb_check("p2_state_full", 32'(state), 32'(2));
        tb_check("p2_log_size", 32'(write_log.size()), 32'(64));
        tb_check("p2_word0", 32'(log_at(0)), 32'({4'b0001, 4'd0, 16'hB000}));
        tb_check("p2_word15", 32'(log_at(15)), 32'({4'b0001, 4'd15, 16'hB00F}));
        tb_check("p2_word16", 32'(log_at(16)), 32'({4'b0010, 4'd0, 16'hB010}));
        tb_check("p2_word36", 32'(log_at(36)), 32'({4'b0100, 4'd4, 16'hB024}));
        tb_check("p2_word40", 32'(log_at(40)), 32'({4'b0100, 4'd8, 16'hB028}));
        tb_check("p2_word63", 32'(log_at(63)), 32'({4'b1000, 4'd15, 16'hB03F}));
        do_release();

        // Reset mid-fill after 30 accepts
        step();
        for (int k = 0; k < 30; k++) begin
            in_valid = 1'b1;
            in_data  = 16'hC000 + 16'(k);
            step();
        end
        tb_check("pre_rst_wren", 32'(wren), 32'(4'b0010));
        #2;
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        tb_check("rst_wren", 32'(wren), 32'(0));
        tb_check("rst_count", 32'(word_count), 32'(0));
        tb_check("rst_state", 32'(state), 32'(0));
        tb_check("rst_addr", 32'(addr), 32'(0));
        step();
        reset = 1'b0;
        step();
        tb_check("p4_state", 32'(state), 32'(1));
        write_log.delete();
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 16'hD000 + 16'(k);
            step();
        end
        in_valid = 1'b0;
        enable   = 1'b0;
        repeat (2) step();
        tb_check("p4_word0", 32'(log_at(0)), 32'({4'b0001, 4'd0, 16'hD000}));
        tb_check("p4_word1", 32'(log_at(1)), 32'({4'b0001, 4'd1, 16'hD001}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
